product_bcd_conv: RTL and testbench

Downstream display stage for the 8-bit add-shift multiplier. It captures the 16-bit product held in the multiplier's A (upper byte) and B (lower byte) registers once a multiply completes. It converts the product to sign plus five BCD digits with a sequential double-dabble engine, one shift per clock. Results are held stable for the hex display drivers until the next conversion.

---
 rtl/product_bcd_conv.sv | 157 +++++++++++++++
 tb/tb_product_bcd_conv.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_conv.sv
// Converts the multiplier's 16-bit product {Aval,Bval} to sign plus five BCD digits (double dabble, one shift per clock).
// Define BCD_SIGNED_EN to treat the product as two's complement; otherwise it is unsigned and Neg stays 0.
module product_bcd_conv (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  Aval,
    input  logic [7:0]  Bval,
    output logic        Busy,
    output logic        Done,
    output logic        Neg,
    output logic [19:0] Bcd,
    output logic [4:0]  Blank
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [15:0] r_mag;
    logic [19:0] r_scr;
    logic [3:0]  r_cnt;
    logic        r_sign;

    logic        r_busy;
    logic        r_done;
    logic        r_neg;
    logic [19:0] r_bcd;
    logic [4:0]  r_blank;

    logic [15:0] w_prod;
    logic [15:0] w_mag;
    logic        w_sign;
    logic [19:0] w_scrAdj;
    logic [35:0] w_shifted;
    logic [19:0] w_newScr;
    logic [4:0]  w_blank;
    logic        w_accept;
    logic        w_last;

    assign w_prod = {Aval, Bval};

`ifdef BCD_SIGNED_EN
    // 0x8000 negates to itself, which read as unsigned is exactly 32768.
    assign w_sign = w_prod[15];
    assign w_mag  = w_sign ? (~w_prod + 16'd1) : w_prod;
`else
    assign w_sign = 1'b0;
    assign w_mag  = w_prod;
`endif

    always_comb begin
        w_scrAdj = r_scr;
        for (int i = 0; i < 5; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) begin
                w_scrAdj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_scrAdj, r_mag} << 1;
    assign w_newScr  = w_shifted[35:16];

    // A digit is blanked only when it and every digit above it are zero; the units digit always shows.
    always_comb begin
        w_blank    = 5'b00000;
        w_blank[4] = (w_newScr[19:16] == 4'd0);
        w_blank[3] = (w_newScr[19:12] == 8'd0);
        w_blank[2] = (w_newScr[19:8]  == 12'd0);
        w_blank[1] = (w_newScr[19:4]  == 16'd0);
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_accept    = 1'b1;
                    w_nextState = CONV;
                end
            end
            CONV: begin
                if (r_cnt == 4'd15) begin
                    w_last      = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mag  <= 16'd0;
            r_scr  <= 20'd0;
            r_cnt  <= 4'd0;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_mag  <= w_mag;
            r_sign <= w_sign;
            r_scr  <= 20'd0;
            r_cnt  <= 4'd0;
        end else if (r_state == CONV) begin
            r_scr <= w_newScr;
            r_mag <= w_shifted[15:0];
            if (!w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Visible results load only on the final iteration, so the display never sees a partial value.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_bcd   <= 20'h00000;
            r_blank <= 5'b11110;
        end else begin
            r_busy <= (w_nextState != IDLE);
            r_done <= w_last;
            if (w_last) begin
                r_bcd   <= w_newScr;
                r_neg   <= r_sign;
                r_blank <= w_blank;
            end
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Neg   = r_neg;
    assign Bcd   = r_bcd;
    assign Blank = r_blank;

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed testbench for product_bcd_conv: latency, signed/unsigned results, blanking,
// ignored restarts, asynchronous reset abort and back-to-back conversions with Start held high.
module tb_product_bcd_conv;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [7:0]  Aval;
    logic [7:0]  Bval;
    logic        Busy;
    logic        Done;
    logic        Neg;
    logic [19:0] Bcd;
    logic [4:0]  Blank;

    int testsRun;
    int testsFailed;
    int edgeCount;

    product_bcd_conv dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Aval  (Aval),
        .Bval  (Bval),
        .Busy  (Busy),
        .Done  (Done),
        .Neg   (Neg),
        .Bcd   (Bcd),
        .Blank (Blank)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present operands with Start for exactly one accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        Aval  = a;
        Bval  = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Returns the number of edges until Done is seen, or -1 if it never comes.
    task automatic waitDone(output int edges);
        edges = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk);
            #1;
            if (Done === 1'b1) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        Reset = 1'b0;
        Start = 1'b0;
        Aval  = 8'h00;
        Bval  = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_busy",  32'(Busy),  32'd0);
        checkOutput("rst_done",  32'(Done),  32'd0);
        checkOutput("rst_neg",   32'(Neg),   32'd0);
        checkOutput("rst_bcd",   32'(Bcd),   32'h00000);
        checkOutput("rst_blank", 32'(Blank), 32'b11110);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // 0x0007
        applyStimulus(8'h00, 8'h07);
        checkOutput("p7_busy_start", 32'(Busy), 32'd1);
        waitDone(edgeCount);
        checkOutput("p7_latency", 32'(edgeCount), 32'd16);
        checkOutput("p7_neg",     32'(Neg),   32'd0);
        checkOutput("p7_bcd",     32'(Bcd),   32'h00007);
        checkOutput("p7_blank",   32'(Blank), 32'b11110);
        checkOutput("p7_busy_done", 32'(Busy), 32'd1);
        @(posedge Clk);
        #1;
        checkOutput("p7_done_pulse", 32'(Done), 32'd0);
        checkOutput("p7_busy_idle",  32'(Busy), 32'd0);
        checkOutput("p7_bcd_hold",   32'(Bcd),  32'h00007);

        // 0xFFF9
        applyStimulus(8'hFF, 8'hF9);
        waitDone(edgeCount);
        checkOutput("pfff9_latency", 32'(edgeCount), 32'd16);
`ifdef BCD_SIGNED_EN
        checkOutput("pfff9_neg",   32'(Neg),   32'd1);
        checkOutput("pfff9_bcd",   32'(Bcd),   32'h00007);
        checkOutput("pfff9_blank", 32'(Blank), 32'b11110);
`else
        checkOutput("pfff9_neg",   32'(Neg),   32'd0);
        checkOutput("pfff9_bcd",   32'(Bcd),   32'h65529);
        checkOutput("pfff9_blank", 32'(Blank), 32'b00000);
`endif
        @(posedge Clk);
        #1;

        // 0x8000 then 0x7FFF
        applyStimulus(8'h80, 8'h00);
        waitDone(edgeCount);
        checkOutput("p8000_latency", 32'(edgeCount), 32'd16);
`ifdef BCD_SIGNED_EN
        checkOutput("p8000_neg", 32'(Neg), 32'd1);
`else
        checkOutput("p8000_neg", 32'(Neg), 32'd0);
`endif
        checkOutput("p8000_bcd",   32'(Bcd),   32'h32768);
        checkOutput("p8000_blank", 32'(Blank), 32'b00000);
        @(posedge Clk);
        #1;
        applyStimulus(8'h7F, 8'hFF);
        waitDone(edgeCount);
        checkOutput("p7fff_neg",   32'(Neg),   32'd0);
        checkOutput("p7fff_bcd",   32'(Bcd),   32'h32767);
        checkOutput("p7fff_blank", 32'(Blank), 32'b00000);
        @(posedge Clk);
        #1;

        // Restart attempt at cycle 5 with new operands must be ignored
        applyStimulus(8'h01, 8'h00);
        repeat (4) @(posedge Clk);
        #1;
        Aval  = 8'h00;
        Bval  = 8'h09;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        checkOutput("restart_busy",     32'(Busy), 32'd1);
        checkOutput("restart_bcd_hold", 32'(Bcd),  32'h32767);
        checkOutput("restart_done_low", 32'(Done), 32'd0);
        waitDone(edgeCount);
        checkOutput("restart_latency", 32'(edgeCount), 32'd11);
        checkOutput("restart_bcd",     32'(Bcd),   32'h00256);
        checkOutput("restart_blank",   32'(Blank), 32'b11000);
        checkOutput("restart_neg",     32'(Neg),   32'd0);
        @(posedge Clk);
        #1;

        // Reset abort mid-conversion
        applyStimulus(8'h00, 8'h63);
        waitDone(edgeCount);
        checkOutput("p99_bcd",   32'(Bcd),   32'h00099);
        checkOutput("p99_blank", 32'(Blank), 32'b11100);
        @(posedge Clk);
        #1;
        applyStimulus(8'h12, 8'h34);
        repeat (7) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        checkOutput("abort_busy",  32'(Busy),  32'd0);
        checkOutput("abort_done",  32'(Done),  32'd0);
        checkOutput("abort_neg",   32'(Neg),   32'd0);
        checkOutput("abort_bcd",   32'(Bcd),   32'h00000);
        checkOutput("abort_blank", 32'(Blank), 32'b11110);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        waitDone(edgeCount);
        checkOutput("abort_no_done", 32'(edgeCount), 32'hFFFFFFFF);

        // Start held high: conversions back to back every 18 cycles
        Aval  = 8'h00;
        Bval  = 8'h0A;
        Start = 1'b1;
        waitDone(edgeCount);
        checkOutput("held_first_latency", 32'(edgeCount), 32'd17);
        checkOutput("held_first_bcd",     32'(Bcd),   32'h00010);
        checkOutput("held_first_blank",   32'(Blank), 32'b11100);
        waitDone(edgeCount);
        checkOutput("held_spacing",    32'(edgeCount), 32'd18);
        checkOutput("held_second_bcd", 32'(Bcd), 32'h00010);
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("held_stop_busy", 32'(Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
